// File: rtl/whack_pkg.sv
// Shared types and constants for the Whack-A-Mole round controller.
// The optional WRONG_PENALTY_EN macro is consumed by mole_round_controller.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_WAIT,
        ST_HIT,
        ST_MISS,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int             LFSR_W            = 8;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
    localparam logic [LFSR_W-1:0] LFSR_TAPS      = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'hA5;

    localparam int             SCORE_W           = 10;
    localparam int             MISS_W            = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX     = 10'd999;
    localparam logic [MISS_W-1:0]  MISS_MAX      = 8'd255;

    function automatic logic [7:0] mole_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick mole positions.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_reg;
    logic              feedback;

    assign feedback = ^(lfsr_reg & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[LFSR_W-2:0], feedback};
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/mole_round_controller.sv
// Whack-A-Mole round sequencer: spawns moles, times hit windows, keeps score.
// Define WRONG_PENALTY_EN to turn a wrong-switch rise during the window into a miss.
module mole_round_controller
    import whack_pkg::*;
#(
    parameter int                WINDOW_CYCLES = 50_000_000,
    parameter int                GAP_CYCLES    = 25_000_000,
    parameter int                NUM_ROUNDS    = 20,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           switches,
    output logic [7:0]           leds,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic [7:0]           round_idx,
    output logic                 busy,
    output logic                 game_over,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam int CNT_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

    // Switch conditioning: two-flop synchronizer, then edge detect
    logic [7:0] sync1_reg, sync2_reg, prev_reg;
    logic [7:0] rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= switches;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rise
            assign rise[gi] = sync2_reg[gi] & ~prev_reg[gi];
        end
    endgenerate

    logic [LFSR_W-1:0] lfsr_value;
    logic              lfsr_unused;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    assign lfsr_unused = ^lfsr_value[LFSR_W-1:3];

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [2:0]           mole_reg, mole_next;
    logic [2:0]           mole_pick;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [MISS_W-1:0]    misses_reg, misses_next;
    logic [7:0]           round_reg, round_next;
    logic [7:0]           leds_reg, leds_next;
    logic                 busy_reg, busy_next;
    logic                 game_over_reg, game_over_next;
    logic                 hit_reg, hit_next;
    logic                 miss_reg, miss_next;
    logic                 correct_rise;

    // Bumping a repeated candidate keeps consecutive moles distinct
    assign mole_pick    = (lfsr_value[2:0] == mole_reg) ? lfsr_value[2:0] + 3'd1 : lfsr_value[2:0];
    assign correct_rise = rise[mole_reg];

`ifdef WRONG_PENALTY_EN
    logic wrong_rise;
    assign wrong_rise = |(rise & ~mole_onehot(mole_reg));
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        mole_next   = mole_reg;
        score_next  = score_reg;
        misses_next = misses_reg;
        round_next  = round_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    score_next  = '0;
                    misses_next = '0;
                    round_next  = '0;
                    state_next  = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                mole_next  = mole_pick;
                cnt_next   = WINDOW_LOAD;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A correct rise wins even on the final window cycle
                if (correct_rise) begin
                    state_next = ST_HIT;
`ifdef WRONG_PENALTY_EN
                end else if (wrong_rise) begin
                    state_next = ST_MISS;
`endif
                end else if (cnt_reg == '0) begin
                    state_next = ST_MISS;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_HIT: begin
                if (score_reg < SCORE_MAX) begin
                    score_next = score_reg + 10'd1;
                end
                round_next = round_reg + 8'd1;
                cnt_next   = GAP_LOAD;
                state_next = ST_GAP;
            end
            ST_MISS: begin
                if (misses_reg < MISS_MAX) begin
                    misses_next = misses_reg + 8'd1;
                end
                round_next = round_reg + 8'd1;
                cnt_next   = GAP_LOAD;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = (round_reg == 8'(NUM_ROUNDS)) ? ST_DONE : ST_SPAWN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registers line up with it
        leds_next = 8'h00;
        if (state_next == ST_WAIT) begin
            leds_next = mole_onehot(mole_next);
        end else if (state_next == ST_DONE) begin
            leds_next = 8'hFF;
        end
        busy_next      = (state_next != ST_IDLE) && (state_next != ST_DONE);
        game_over_next = (state_next == ST_DONE);
        hit_next       = (state_next == ST_HIT);
        miss_next      = (state_next == ST_MISS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            mole_reg      <= '0;
            score_reg     <= '0;
            misses_reg    <= '0;
            round_reg     <= '0;
            leds_reg      <= '0;
            busy_reg      <= 1'b0;
            game_over_reg <= 1'b0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mole_reg      <= mole_next;
            score_reg     <= score_next;
            misses_reg    <= misses_next;
            round_reg     <= round_next;
            leds_reg      <= leds_next;
            busy_reg      <= busy_next;
            game_over_reg <= game_over_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
        end
    end

    assign leds       = leds_reg;
    assign score      = score_reg;
    assign misses     = misses_reg;
    assign round_idx  = round_reg;
    assign busy       = busy_reg;
    assign game_over  = game_over_reg;
    assign hit_pulse  = hit_reg;
    assign miss_pulse = miss_reg;

endmodule
